ppi_bus_master: RTL and testbench
=================================

# ppi_bus_master

Synchronous bus-cycle sequencer that drives the CPU side of our 8255A PPI model. It accepts read, write and PPI-reset commands over a valid/ready interface and generates `nCs`/`nRe`/`nWr`/`Reset`/`A` strobes on the packed 6-bit `control` bus with programmable setup, strobe and hold widths. Write data is driven onto the shared `PD` data bus; read data is captured from it. It is the initiator for all PPI port blocks and sits between the system controller and the PPI.

## Interface
Parameters:
- `SETUP_CYC`, 1, cycles `nCs`/`A` valid before strobe (min 1)
- `STROBE_CYC`, 2, cycles `nRe`/`nWr`/`Reset` asserted (min 1)
- `HOLD_CYC`, 1, cycles after strobe with `nCs`/`A`/data held (0 allowed)

Ports:
- `clk`  in  1  single system clock, rising edge
- `Reset`  in  1  synchronous, active-high block reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_op`  in  2  00 read, 01 write, 10 PPI reset pulse, 11 reserved (treated as read)
- `cmd_addr`  in  2  PPI address A[1:0] (11 = control word)
- `cmd_data`  in  8  write data
- `rsp_valid`  out  1  cycle complete
- `rsp_ready`  in  1  response consumed
- `rsp_data`  out  8  read data (0 for writes/reset op)
- `control`  out  6  {nCs, nRe, nWr, Reset, A[1:0]} to PPI
- `PD`  inout  8  PPI data bus; driven only during write SETUP/STROBE/HOLD, else hi-Z
- `busy`  out  1  high in any state except IDLE
- `cw_shadow`  out  8  last control word written (see Configuration)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch op/addr/data, go SETUP.
- SETUP: for read/write, `nCs`=0, `A`=latched addr, strobes high; write drives `PD`. For reset op, `nCs`=1, `A`=00. Lasts SETUP_CYC cycles, then STROBE.
- STROBE: read `nRe`=0; write `nWr`=0; reset op `Reset`=1. Lasts STROBE_CYC cycles. Read data sampled from `PD` at the clock edge ending the last STROBE cycle.
- HOLD: strobes deasserted, `nCs`/`A`/`PD` drive held, HOLD_CYC cycles; skipped when HOLD_CYC=0.
- RESP: bus idle (`control`=6'b111000, `PD` hi-Z), `rsp_valid`=1, `rsp_data` stable until `rsp_valid`&&`rsp_ready`, then IDLE. `cmd_ready`=0 in RESP; no command overlap.
- Per-phase cycle count is one down-counter loaded on each state entry; 8-bit, parameters must be ≤255.

## Timing
- Reset values: `control`=6'b111000, `PD` hi-Z, `cmd_ready`=0 during reset then 1 from the first cycle after it, `rsp_valid`=0, `rsp_data`=8'h00, `busy`=0, `cw_shadow`=8'h00.
- Defaults (1,2,1): accept edge cycle 0; SETUP cycle 1; STROBE cycles 2–3; HOLD cycle 4; `rsp_valid` in cycle 5. Latency = SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
- With `rsp_ready` held high, the next command can be accepted 1 cycle after the response handshake, because IDLE is re-entered first.
- Reset mid-operation aborts immediately. Bus returns to the reset values on that edge. No response is issued.
- `control` and `PD` enable are registered outputs, so there are no combinational glitches on the strobes.

## Configuration
- `PPI_CW_SHADOW_EN` defined: on every completed write with addr=11 and data[7]=1, `cw_shadow` is updated at HOLD exit (or STROBE exit if HOLD_CYC=0). Bit-set/reset writes (data[7]=0) do not update it.
- Not defined: `cw_shadow` is tied to 8'h00 and no register is inferred.

## Structure
- `ppi_pkg` holds the FSM state enum, op codes (OP_READ/OP_WRITE/OP_RESET), the address constant ADDR_CW=2'b11, and CTRL_IDLE=6'b111000.
- One sub-module: `ppi_cycle_timer`, a loadable down-counter with a `done` flag, used for all phases.

## Test plan
- Write 0x80 to addr 3 (defaults) → `control` sequence 111000, 011011, 010011 ×2, 011011, 111000. `PD`=0x80 during cycles 1–4. `rsp_valid` at cycle 5. `cw_shadow`=0x80 when the macro is defined.
- Read addr 0 with PPI model driving 0x5A → `nRe` low in cycles 2–3. `rsp_data`=0x5A at cycle 5. `PD` never driven by the master.
- `rsp_ready` low for 4 cycles → `rsp_valid`/`rsp_data` stable. `cmd_ready`=0 throughout. A new command is accepted 1 cycle after the handshake.
- Reset op → `nCs`=1 throughout, `Reset` bit high in exactly 2 cycles, `rsp_data`=0x00.
- `Reset` asserted during STROBE of a write → next cycle `control`=111000, `PD` hi-Z, no `rsp_valid`.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=0 → write latency 5 cycles. HOLD state is never entered.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus master: FSM states, op codes,
// the control-word address and the idle value of the packed control bus.
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] ADDR_CW   = 2'b11;
    localparam logic [5:0] CTRL_IDLE = 6'b111000;

    // The reserved op code collapses onto a plain read.
    function automatic logic [1:0] decode_op(input logic [1:0] op);
        return (op == OP_WRITE || op == OP_RESET) ? op : OP_READ;
    endfunction

    // Packed bus word {nCs, nRe, nWr, Reset, A[1:0]} for a given state and op.
    function automatic logic [5:0] ctrl_word(input state_t st, input logic [1:0] op,
                                             input logic [1:0] addr);
        logic [5:0] w;
        logic       strobe;
        w      = CTRL_IDLE;
        strobe = (st == ST_STROBE);
        if (st == ST_SETUP || st == ST_STROBE || st == ST_HOLD) begin
            if (op == OP_RESET) begin
                w = {3'b111, strobe, 2'b00};
            end else begin
                w = {1'b0, !(strobe && op == OP_READ), !(strobe && op == OP_WRITE), 1'b0, addr};
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ppi_cycle_timer.sv
// Loadable 8-bit down-counter; done is high while the count sits at zero,
// so loading N-1 on phase entry yields a phase lasting N cycles.
module ppi_cycle_timer (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign done = (count_reg == 8'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Bus-cycle sequencer for the 8255A PPI model (read / write / PPI reset pulse).
// Optional feature: define PPI_CW_SHADOW_EN to keep a shadow of the last mode control word.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [5:0] control,
    inout  wire  [7:0] PD,
    output logic       busy,
    output logic [7:0] cw_shadow
);

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);

    state_t     state_reg, state_next;
    logic [1:0] op_reg, addr_reg;
    logic [7:0] wdata_reg, rsp_data_reg;
    logic [5:0] control_reg, control_next;
    logic       pd_oe_reg, pd_oe_next;
    logic [1:0] op_eff, addr_eff;
    logic       timer_load, timer_done, accept;
    logic [7:0] timer_val;

    ppi_cycle_timer u_timer (
        .clk      (clk),
        .srst     (Reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign cmd_ready = (state_reg == ST_IDLE) && !Reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_data  = rsp_data_reg;
    assign control   = control_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept)     state_next = ST_SETUP;
            ST_SETUP:  if (timer_done) state_next = ST_STROBE;
            ST_STROBE: if (timer_done) state_next = (HOLD_CYC == 0) ? ST_RESP : ST_HOLD;
            ST_HOLD:   if (timer_done) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase

        timer_load = (state_next != state_reg);
        case (state_next)
            ST_SETUP:  timer_val = SETUP_LD;
            ST_STROBE: timer_val = STROBE_LD;
            ST_HOLD:   timer_val = HOLD_LD;
            default:   timer_val = 8'd0;
        endcase

        // Outputs are registered from the next state, so on the accept edge the
        // live command fields stand in for the not-yet-latched ones.
        op_eff       = (state_reg == ST_IDLE) ? decode_op(cmd_op) : op_reg;
        addr_eff     = (state_reg == ST_IDLE) ? cmd_addr : addr_reg;
        control_next = ctrl_word(state_next, op_eff, addr_eff);
        pd_oe_next   = (op_eff == OP_WRITE) &&
                       (state_next == ST_SETUP || state_next == ST_STROBE || state_next == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            control_reg  <= CTRL_IDLE;
            pd_oe_reg    <= 1'b0;
            op_reg       <= OP_READ;
            addr_reg     <= 2'b00;
            wdata_reg    <= 8'h00;
            rsp_data_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            control_reg <= control_next;
            pd_oe_reg   <= pd_oe_next;
            if (accept) begin
                op_reg       <= decode_op(cmd_op);
                addr_reg     <= cmd_addr;
                wdata_reg    <= cmd_data;
                rsp_data_reg <= 8'h00;
            end
            if (state_reg == ST_STROBE && timer_done && op_reg == OP_READ) begin
                rsp_data_reg <= PD;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_pd
        assign PD[gi] = pd_oe_reg ? wdata_reg[gi] : 1'bz;
    end

`ifdef PPI_CW_SHADOW_EN
    logic [7:0] cw_shadow_reg;
    logic       cw_commit;

    // The write is complete once the last bus phase (HOLD, or STROBE without HOLD) ends.
    assign cw_commit = timer_done &&
                       ((state_reg == ST_HOLD) || (state_reg == ST_STROBE && HOLD_CYC == 0));

    always_ff @(posedge clk) begin
        if (Reset) begin
            cw_shadow_reg <= 8'h00;
        end else if (cw_commit && op_reg == OP_WRITE && addr_reg == ADDR_CW && wdata_reg[7]) begin
            cw_shadow_reg <= wdata_reg;
        end
    end

    assign cw_shadow = cw_shadow_reg;
`else
    assign cw_shadow = 8'h00;
`endif

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: two instances (default timing and 3/1/0 timing), a
// transaction-level expected-waveform model, one per-cycle compare process.
`timescale 1ns/1ps
module tb_ppi_bus_master;

    localparam logic [5:0] CTRL_IDLE_L = 6'b111000;
    localparam logic [7:0] FLOAT       = 8'hFF;   // undriven PD reads back through pull-ups
    localparam int         LOGN        = 8192;

    typedef struct packed {
        logic [5:0] ctrl;
        logic [7:0] pd;
        logic       rv;
        logic [7:0] rd;
        logic       busy;
        logic       cr;
        logic [7:0] cw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid [2];
    logic [1:0] cmd_op    [2];
    logic [1:0] cmd_addr  [2];
    logic [7:0] cmd_data  [2];
    logic       rsp_ready [2];
    logic [7:0] ppi_val   [2];
    wire        cmd_ready [2];
    wire        rsp_valid [2];
    wire  [7:0] rsp_data  [2];
    wire  [5:0] control   [2];
    wire        busy      [2];
    wire  [7:0] cw_shadow [2];
    wire  [7:0] pd_obs    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wire [7:0] pd;
        ppi_bus_master #(
            .SETUP_CYC  ((gi == 0) ? 1 : 3),
            .STROBE_CYC ((gi == 0) ? 2 : 1),
            .HOLD_CYC   ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .Reset     (rst),
            .cmd_valid (cmd_valid[gi]),
            .cmd_ready (cmd_ready[gi]),
            .cmd_op    (cmd_op[gi]),
            .cmd_addr  (cmd_addr[gi]),
            .cmd_data  (cmd_data[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_data  (rsp_data[gi]),
            .control   (control[gi]),
            .PD        (pd),
            .busy      (busy[gi]),
            .cw_shadow (cw_shadow[gi])
        );
        // PPI model: drives its read value while selected and read-strobed.
        assign pd = (!control[gi][5] && !control[gi][4]) ? ppi_val[gi] : 8'hzz;
        for (genvar bi = 0; bi < 8; bi++) begin : g_pu
            pullup pu (pd[bi]);
        end
        assign pd_obs[gi] = pd;
    end

    int   cyc = 0;
    always @(posedge clk) cyc++;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic check_en = 1'b0;
    exp_t exp_q [2][$];
    logic [7:0] shadow_m [2];

    logic [5:0] ctrl_log [2][LOGN];
    logic [7:0] pd_log   [2][LOGN];
    logic       rv_log   [2][LOGN];
    logic [7:0] rd_log   [2][LOGN];
    logic       busy_log [2][LOGN];
    logic       cr_log   [2][LOGN];

    function automatic int cfg_s(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int cfg_t(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int cfg_h(input int i); return (i == 0) ? 1 : 0; endfunction
    function automatic int li(input int c); return c % LOGN; endfunction

    function automatic logic [1:0] norm_op(input logic [1:0] op);
        return (op == 2'b01 || op == 2'b10) ? op : 2'b00;
    endfunction

    // phase 1 = strobe window, 0 = setup/hold window
    function automatic logic [5:0] bus_word(input int phase, input logic [1:0] op,
                                            input logic [1:0] addr);
        logic is_rd, is_wr, is_rs, stb;
        is_rd = (op == 2'b00);
        is_wr = (op == 2'b01);
        is_rs = (op == 2'b10);
        stb   = (phase == 1);
        return {is_rs, !(stb && is_rd), !(stb && is_wr), stb && is_rs, is_rs ? 2'b00 : addr};
    endfunction

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc%0d: got %h, want %h", name, i, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                ctrl_log[i][li(cyc)] = control[i];
                pd_log[i][li(cyc)]   = pd_obs[i];
                rv_log[i][li(cyc)]   = rsp_valid[i];
                rd_log[i][li(cyc)]   = rsp_data[i];
                busy_log[i][li(cyc)] = busy[i];
                cr_log[i][li(cyc)]   = cmd_ready[i];
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                end else begin
                    e = '{ctrl: CTRL_IDLE_L, pd: FLOAT, rv: 1'b0, rd: 8'h00,
                          busy: 1'b0, cr: !rst, cw: shadow_m[i]};
                end
                chk("control", i, 8'(control[i]), 8'(e.ctrl));
                chk("pd", i, pd_obs[i], e.pd);
                chk("rsp_valid", i, 8'(rsp_valid[i]), 8'(e.rv));
                if (e.rv) chk("rsp_data", i, rsp_data[i], e.rd);
                chk("busy", i, 8'(busy[i]), 8'(e.busy));
                chk("cmd_ready", i, 8'(cmd_ready[i]), 8'(e.cr));
                chk("cw_shadow", i, cw_shadow[i], e.cw);
            end
        end
    end

    // Issues one command from an IDLE cycle, queues its expected waveform, holds
    // rsp_ready low for w RESP cycles, returns in the IDLE cycle after the handshake.
    task automatic run_txn(input int i, input logic [1:0] op, input logic [1:0] addr,
                           input logic [7:0] data, input logic [7:0] pv, input int w,
                           output int c0);
        logic [1:0] nop;
        logic [7:0] cw_new;
        int         s, t, h, lat, phase;
        exp_t       e;
        nop = norm_op(op);
        s = cfg_s(i); t = cfg_t(i); h = cfg_h(i);
        lat = s + t + h + 1;
        c0 = cyc;
        ppi_val[i]   = pv;
        cmd_valid[i] = 1'b1;
        cmd_op[i]    = op;
        cmd_addr[i]  = addr;
        cmd_data[i]  = data;
        rsp_ready[i] = 1'b0;
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
        cw_new = shadow_m[i];
`ifdef PPI_CW_SHADOW_EN
        if (nop == 2'b01 && addr == 2'b11 && data[7]) cw_new = data;
`endif
        for (int k = 0; k < s + t + h; k++) begin
            phase  = (k >= s && k < s + t) ? 1 : 0;
            e.ctrl = bus_word(phase, nop, addr);
            e.pd   = (nop == 2'b01) ? data : ((phase == 1 && nop == 2'b00) ? pv : FLOAT);
            e.rv   = 1'b0;
            e.rd   = 8'h00;
            e.busy = 1'b1;
            e.cr   = 1'b0;
            e.cw   = shadow_m[i];
            exp_q[i].push_back(e);
        end
        for (int k = 0; k <= w; k++) begin
            e = '{ctrl: CTRL_IDLE_L, pd: FLOAT, rv: 1'b1, rd: (nop == 2'b00) ? pv : 8'h00,
                  busy: 1'b1, cr: 1'b0, cw: cw_new};
            exp_q[i].push_back(e);
        end
        shadow_m[i] = cw_new;
        // Offer junk commands while busy: none of them may be accepted.
        for (int k = 1; k < lat + w; k++) begin
            cmd_valid[i] = 1'($urandom_range(0, 1));
            cmd_op[i]    = 2'($urandom);
            cmd_addr[i]  = 2'($urandom);
            cmd_data[i]  = 8'($urandom);
            @(posedge clk); #1;
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        cmd_valid[i] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [5:0] wr_seq [6];
    int c0, c1, nrst;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = 2'b00; cmd_addr[i] = 2'b00;
            cmd_data[i] = 8'h00; rsp_ready[i] = 1'b0; ppi_val[i] = 8'h00; shadow_m[i] = 8'h00;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;
        idle_cycles(2);
        chk("reset_rsp_data", 0, rsp_data[0], 8'h00);
        chk("reset_cw_shadow", 1, cw_shadow[1], 8'h00);
        chk("reset_control", 0, 8'(control[0]), 8'h38);
        rst = 1'b0;
        idle_cycles(1);

        // Write 0x80 to the control word, default timing.
        run_txn(0, 2'b01, 2'b11, 8'h80, 8'h00, 0, c0);
        wr_seq[0] = 6'b111000; wr_seq[1] = 6'b011011; wr_seq[2] = 6'b010011;
        wr_seq[3] = 6'b010011; wr_seq[4] = 6'b011011; wr_seq[5] = 6'b111000;
        for (int k = 0; k < 6; k++) chk("wr_ctrl_seq", 0, 8'(ctrl_log[0][li(c0 + k)]), 8'(wr_seq[k]));
        for (int k = 1; k <= 4; k++) chk("wr_pd", 0, pd_log[0][li(c0 + k)], 8'h80);
        chk("wr_rv_c4", 0, 8'(rv_log[0][li(c0 + 4)]), 8'h00);
        chk("wr_rv_c5", 0, 8'(rv_log[0][li(c0 + 5)]), 8'h01);
`ifdef PPI_CW_SHADOW_EN
        chk("wr_cw_shadow", 0, cw_shadow[0], 8'h80);
`else
        chk("wr_cw_shadow", 0, cw_shadow[0], 8'h00);
`endif
        idle_cycles(1);

        // Read addr 0, PPI returns 0x5A, response held off for 4 cycles, then back-to-back.
        run_txn(0, 2'b00, 2'b00, 8'hC3, 8'h5A, 4, c0);
        chk("rd_nre_c1", 0, 8'(ctrl_log[0][li(c0 + 1)][4]), 8'h01);
        chk("rd_nre_c2", 0, 8'(ctrl_log[0][li(c0 + 2)][4]), 8'h00);
        chk("rd_nre_c3", 0, 8'(ctrl_log[0][li(c0 + 3)][4]), 8'h00);
        chk("rd_nre_c4", 0, 8'(ctrl_log[0][li(c0 + 4)][4]), 8'h01);
        for (int k = 5; k <= 9; k++) begin
            chk("rd_rsp_data", 0, rd_log[0][li(c0 + k)], 8'h5A);
            chk("rd_rsp_valid", 0, 8'(rv_log[0][li(c0 + k)]), 8'h01);
        end
        for (int k = 1; k <= 9; k++) chk("rd_cmd_ready", 0, 8'(cr_log[0][li(c0 + k)]), 8'h00);
        run_txn(0, 2'b01, 2'b01, 8'h33, 8'h00, 0, c1);
        chk("b2b_idle_c10", 0, 8'(busy_log[0][li(c0 + 10)]), 8'h00);
        chk("b2b_busy_c11", 0, 8'(busy_log[0][li(c0 + 11)]), 8'h01);
        idle_cycles(1);

        // PPI reset op.
        run_txn(0, 2'b10, 2'b10, 8'hFF, 8'h77, 0, c0);
        nrst = 0;
        for (int k = 0; k <= 5; k++) nrst += int'(ctrl_log[0][li(c0 + k)][2]);
        chk("rstop_pulse_len", 0, 8'(nrst), 8'd2);
        for (int k = 1; k <= 5; k++) chk("rstop_ncs", 0, 8'(ctrl_log[0][li(c0 + k)][5]), 8'h01);
        chk("rstop_rsp_data", 0, rd_log[0][li(c0 + 5)], 8'h00);
        idle_cycles(1);

        // Block reset during the STROBE of a write.
        c0 = cyc;
        cmd_valid[0] = 1'b1; cmd_op[0] = 2'b01; cmd_addr[0] = 2'b01; cmd_data[0] = 8'h3C;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        exp_q[0].push_back('{ctrl: 6'b011001, pd: 8'h3C, rv: 1'b0, rd: 8'h00, busy: 1'b1, cr: 1'b0, cw: shadow_m[0]});
        exp_q[0].push_back('{ctrl: 6'b010001, pd: 8'h3C, rv: 1'b0, rd: 8'h00, busy: 1'b1, cr: 1'b0, cw: shadow_m[0]});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        shadow_m[0] = 8'h00;
        shadow_m[1] = 8'h00;
        idle_cycles(4);
        chk("abort_control", 0, 8'(ctrl_log[0][li(c0 + 3)]), 8'h38);
        chk("abort_pd", 0, pd_log[0][li(c0 + 3)], FLOAT);
        for (int k = 3; k <= 6; k++) chk("abort_no_rsp", 0, 8'(rv_log[0][li(c0 + k)]), 8'h00);

        // 3/1/0 instance: latency 5, no HOLD phase.
        run_txn(1, 2'b01, 2'b11, 8'h85, 8'h00, 0, c0);
        chk("fast_setup_c3", 1, 8'(ctrl_log[1][li(c0 + 3)]), 8'h1B);
        chk("fast_strobe_c4", 1, 8'(ctrl_log[1][li(c0 + 4)]), 8'h13);
        chk("fast_rv_c4", 1, 8'(rv_log[1][li(c0 + 4)]), 8'h00);
        chk("fast_rv_c5", 1, 8'(rv_log[1][li(c0 + 5)]), 8'h01);
        chk("fast_ctrl_c5", 1, 8'(ctrl_log[1][li(c0 + 5)]), 8'h38);

        // Randomized traffic across both instances.
        for (int n = 0; n < 80; n++) begin
            int         inst;
            logic [7:0] d;
            inst = $urandom_range(0, 1);
            d    = 8'($urandom);
            run_txn(inst, 2'($urandom), 2'($urandom), d, 8'($urandom), $urandom_range(0, 3), c0);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        for (int i = 0; i < 2; i++) chk("queue_drained", i, 8'(exp_q[i].size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
